filter_block: RTL and testbench

FILTER_BLOCK -- requirements
Module: filter_block

---
 rtl/filter_block_if.sv | 26 ++
 rtl/filter_block.sv | 58 +++++
 tb/tb_filter_block.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/filter_block_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | filter_block_if : sample-in / sample-out bundle for filter_block      |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface filter_block_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_valid;
  logic                  x_parity;
  logic [DATA_WIDTH-1:0] y_data;
  logic                  y_valid;
  logic                  y_parity;

  modport master (
    output x_data, x_valid, x_parity,
    input  y_data, y_valid, y_parity
  );

  modport slave (
    input  x_data, x_valid, x_parity,
    output y_data, y_valid, y_parity
  );
endinterface
`default_nettype wire

// File: rtl/filter_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | filter_block : two parity-checked x2 stages in series (y = 4*x)       |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module filter_block #(
  parameter int DATA_WIDTH = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  filter_block_if.slave    bus
);
  localparam int c_STAGES = 2;

  for (genvar s = 0; s < c_STAGES; s++) begin : g_stage
    logic [DATA_WIDTH-1:0] w_din;
    logic                  w_vin;
    logic                  w_pin;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_parity;

    if (s == 0) begin : g_first
      assign w_din = bus.x_data;
      assign w_vin = bus.x_valid;
      assign w_pin = bus.x_parity;
    end else begin : g_next
      assign w_din = g_stage[s-1].r_data;
      assign w_vin = g_stage[s-1].r_valid;
      assign w_pin = g_stage[s-1].r_parity;
    end

    assign w_accept  = w_vin && (w_pin == ^w_din);
    assign w_shifted = {w_din[DATA_WIDTH-2:0], 1'b0};

    // Rejected or idle cycles drop valid but keep the last good data/parity.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data   <= '0;
        r_valid  <= 1'b0;
        r_parity <= 1'b0;
      end else begin
        r_valid <= w_accept;
        if (w_accept) begin
          r_data   <= w_shifted;
          r_parity <= ^w_shifted;
        end
      end
    end
  end

  assign bus.y_data   = g_stage[c_STAGES-1].r_data;
  assign bus.y_valid  = g_stage[c_STAGES-1].r_valid;
  assign bus.y_parity = g_stage[c_STAGES-1].r_parity;
endmodule
`default_nettype wire

// File: tb/tb_filter_block.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_filter_block : randomized + directed bench with behavioural model  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_filter_block;
  localparam int DATA_WIDTH = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  filter_block_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  filter_block #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the output shows, one edge late, whether the previous edge saw a
  // good sample, and four times the most recent good sample seen so far.
  logic                  m_good;
  logic [DATA_WIDTH-1:0] m_last;
  logic                  exp_valid;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  w_ok;

  assign w_ok = bus.x_valid && (bus.x_parity == ^bus.x_data);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_good    <= 1'b0;
      m_last    <= '0;
      exp_valid <= 1'b0;
      exp_data  <= '0;
    end else begin
      exp_valid <= m_good;
      exp_data  <= DATA_WIDTH'((32'(m_last) * 4) % 65536);
      m_good    <= w_ok;
      if (w_ok) m_last <= bus.x_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    chk("model_valid",  32'(bus.y_valid),  32'(exp_valid));
    chk("model_data",   32'(bus.y_data),   32'(exp_data));
    chk("model_parity", 32'(bus.y_parity), 32'(^exp_data));
  end

  task automatic drive(input logic [DATA_WIDTH-1:0] d, input logic v, input logic p);
    bus.x_data   = d;
    bus.x_valid  = v;
    bus.x_parity = p;
  endtask

  task automatic lit(input string name, input logic [DATA_WIDTH-1:0] d,
                     input logic v, input logic p);
    chk({name, "_data"},   32'(bus.y_data),   32'(d));
    chk({name, "_valid"},  32'(bus.y_valid),  32'(v));
    chk({name, "_parity"}, 32'(bus.y_parity), 32'(p));
  endtask

  initial begin
    logic [DATA_WIDTH-1:0] rd;
    logic                  rv;
    logic                  rp;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(16'd3, 1'b1, 1'b0);
    #1;
    lit("reset_hold", 16'd0, 1'b0, 1'b0);

    // Release with a good sample of 3 already presented.
    @(negedge clk);
    rst = 1'b0;
    #1;
    lit("post_release", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    lit("three", 16'h000C, 1'b1, 1'b0);

    drive(16'h0001, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    lit("one", 16'h0004, 1'b1, 1'b1);

    drive(16'h0002, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    lit("two", 16'h0008, 1'b1, 1'b1);

    drive(16'h4001, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    lit("overflow", 16'h0004, 1'b1, 1'b1);

    drive(16'd3, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    lit("bad_parity", 16'h0004, 1'b0, 1'b1);

    // Back-to-back stream 1, 2, 3 then idle.
    drive(16'd1, 1'b1, 1'b1);
    @(negedge clk);
    drive(16'd2, 1'b1, 1'b1);
    @(negedge clk);
    lit("stream_4", 16'd4, 1'b1, 1'b1);
    drive(16'd3, 1'b1, 1'b0);
    @(negedge clk);
    lit("stream_8", 16'd8, 1'b1, 1'b1);
    drive(16'd0, 1'b0, 1'b0);
    @(negedge clk);
    lit("stream_12", 16'd12, 1'b1, 1'b0);
    @(negedge clk);
    lit("stream_idle", 16'd12, 1'b0, 1'b0);

    // Reset between edges with a sample in flight.
    drive(16'd5, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    lit("midreset", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    drive(16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    lit("after_rst1", 16'd0, 1'b0, 1'b0);
    @(negedge clk);
    lit("after_rst2", 16'd0, 1'b0, 1'b0);

    // Randomized traffic with occasional mid-cycle resets.
    for (int i = 0; i < 600; i++) begin
      rd = DATA_WIDTH'($urandom);
      rv = ($urandom_range(0, 9) < 8);
      rp = ($urandom_range(0, 3) == 0) ? ~(^rd) : (^rd);
      drive(rd, rv, rp);
      if ($urandom_range(0, 59) == 0) begin
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        lit("rand_reset", 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
      end else begin
        @(negedge clk);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
